// File: rtl/sa_feed_ctrl_if.sv
// rtl/sa_feed_ctrl_if.sv - host, operand buffer and PE array signals of the systolic feed sequencer
//
// Signals:
//   start      run request from host
//   busy       run in progress (first RUN cycle through DONE cycle)
//   done       one-cycle pulse: array results final
//   rd_en      operand buffer read strobe
//   rd_addr    k index into A columns / B rows
//   a_rd_data  A column k, row i at [i*DW +: DW], valid the cycle after rd_en
//   b_rd_data  B row k, column j at [j*DW +: DW], valid the cycle after rd_en
//   a_edge     west edge of the array, row i at [i*DW +: DW]
//   b_edge     north edge of the array, column j at [j*DW +: DW]
//   pe_enable  array-wide PE enable
//   pe_clear   PEs load the product instead of accumulating
// Modports: master = host/buffer/array side, slave = sequencer.
interface sa_feed_ctrl_if #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 32,
    parameter int AW = (K > 1) ? $clog2(K) : 1
);
    logic            start;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [N*DW-1:0] a_rd_data;
    logic [N*DW-1:0] b_rd_data;
    logic [N*DW-1:0] a_edge;
    logic [N*DW-1:0] b_edge;
    logic            pe_enable;
    logic            pe_clear;

    modport master (
        output start, a_rd_data, b_rd_data,
        input  busy, done, rd_en, rd_addr, a_edge, b_edge, pe_enable, pe_clear
    );

    modport slave (
        input  start, a_rd_data, b_rd_data,
        output busy, done, rd_en, rd_addr, a_edge, b_edge, pe_enable, pe_clear
    );
endinterface

// File: rtl/sa_feed_ctrl.sv
// rtl/sa_feed_ctrl.sv - sequencer feeding diagonally skewed operands into an NxN systolic PE array
//
// Computes C = A(NxK) * B(KxN) on an external PE array by streaming A columns onto
// the west edge and B rows onto the north edge, row/column i delayed by i cycles.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-high reset
//   bus    sa_feed_ctrl_if.slave (start/busy/done, operand reads, array edges, enable/clear)
// Cycle c = 0 is the first RUN cycle; T = K + 2N - 2 is the cycle in which PE(N-1,N-1)
// accumulates its last product, and the DONE cycle is T + 1.
module sa_feed_ctrl #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 32,
    parameter int AW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          reset,
    sa_feed_ctrl_if.slave bus
);
    localparam int T  = K + 2 * N - 2;
    localparam int CW = $clog2(T + 2);

    localparam logic [CW-1:0] T_C   = CW'(T);
    localparam logic [CW-1:0] K_C   = CW'(K);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            busy_q;
    logic            done_q;
    logic            rd_en_q;
    logic [AW-1:0]   rd_addr_q;
    logic            pe_enable_q;
    logic            pe_clear_q;
    // High in the cycle where buffer data answers a read issued the previous cycle.
    logic            rd_vld;

    logic [N*DW-1:0] a_in;
    logic [N*DW-1:0] b_in;
    logic [N*DW-1:0] a_edge;
    logic [N*DW-1:0] b_edge;

    assign cnt_nxt = cnt + ONE_C;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pe_enable_q <= 1'b0;
            pe_clear_q  <= 1'b0;
            rd_vld      <= 1'b0;
        end else begin
            rd_vld     <= rd_en_q;
            done_q     <= 1'b0;
            pe_clear_q <= 1'b0;
            case (state)
                // START is honoured both when idle and in the DONE cycle, which
                // gives back-to-back runs without an idle bubble.
                S_IDLE, S_DONE: begin
                    pe_enable_q <= 1'b0;
                    if (bus.start) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end else begin
                        state     <= S_IDLE;
                        busy_q    <= 1'b0;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                    end
                end
                S_RUN: begin
                    cnt         <= cnt_nxt;
                    pe_enable_q <= (cnt_nxt <= T_C);
                    pe_clear_q  <= (cnt_nxt == ONE_C);
                    if (cnt_nxt < K_C) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= cnt_nxt[AW-1:0];
                    end else begin
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                    end
                    if (cnt == T_C) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    busy_q      <= 1'b0;
                    rd_en_q     <= 1'b0;
                    rd_addr_q   <= '0;
                    pe_enable_q <= 1'b0;
                end
            endcase
        end
    end

    // Buffer data is only meaningful the cycle after a read; otherwise inject zeros
    // so the array sees clean zero padding around each diagonal wavefront.
    assign a_in = rd_vld ? bus.a_rd_data : '0;
    assign b_in = rd_vld ? bus.b_rd_data : '0;

    // Row/column 0 goes straight to the edge; row/column i passes through i registers.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_edge[0 +: DW] = a_in[0 +: DW];
            assign b_edge[0 +: DW] = b_in[0 +: DW];
        end else begin : g_delay
            logic [DW-1:0] a_stg [0:i-1];
            logic [DW-1:0] b_stg [0:i-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < i; s++) begin
                        a_stg[s] <= '0;
                        b_stg[s] <= '0;
                    end
                end else begin
                    a_stg[0] <= a_in[i*DW +: DW];
                    b_stg[0] <= b_in[i*DW +: DW];
                    for (int s = 1; s < i; s++) begin
                        a_stg[s] <= a_stg[s-1];
                        b_stg[s] <= b_stg[s-1];
                    end
                end
            end

            assign a_edge[i*DW +: DW] = a_stg[i-1];
            assign b_edge[i*DW +: DW] = b_stg[i-1];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.pe_enable = pe_enable_q;
    assign bus.pe_clear  = pe_clear_q;
    assign bus.a_edge    = a_edge;
    assign bus.b_edge    = b_edge;
endmodule

// File: tb/tb_sa_feed_ctrl.sv
// tb/tb_sa_feed_ctrl.sv - directed self-checking bench for sa_feed_ctrl with buffer and 4x4 PE array models
module tb_sa_feed_ctrl;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int DW = 32;
    localparam int AW = 2;
    localparam int T  = K + 2 * N - 2;

    logic clk = 1'b0;
    logic reset;

    sa_feed_ctrl_if #(.N(N), .K(K), .DW(DW), .AW(AW)) bus ();

    sa_feed_ctrl #(.N(N), .K(K), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] a_mem [K][N];
    logic [DW-1:0] b_mem [K][N];

    // Operand buffers: one-cycle read latency, junk when no read was issued.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.rd_en) begin
                bus.a_rd_data[i*DW +: DW] <= a_mem[bus.rd_addr][i];
                bus.b_rd_data[i*DW +: DW] <= b_mem[bus.rd_addr][i];
            end else begin
                bus.a_rd_data[i*DW +: DW] <= 32'hDEAD_BEEF;
                bus.b_rd_data[i*DW +: DW] <= 32'hBAD0_F00D;
            end
        end
    end

    // Output-stationary PE array: a flows east, b flows south.
    logic [DW-1:0] pa [N][N];
    logic [DW-1:0] pb [N][N];
    logic [DW-1:0] pc [N][N];

    function automatic logic [DW-1:0] west_in(input int i, input int j);
        return (j == 0) ? bus.a_edge[i*DW +: DW] : pa[i][j-1];
    endfunction

    function automatic logic [DW-1:0] north_in(input int i, input int j);
        return (i == 0) ? bus.b_edge[j*DW +: DW] : pb[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pa[i][j] <= west_in(i, j);
                pb[i][j] <= north_in(i, j);
                if (bus.pe_enable)
                    pc[i][j] <= bus.pe_clear ? west_in(i, j) * north_in(i, j)
                                             : pc[i][j] + west_in(i, j) * north_in(i, j);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Request a run; returns at the negedge inside cycle c = 0.
    task automatic start_run(input bit keep_start);
        bus.start = 1'b1;
        tick();
        bus.start = keep_start;
    endtask

    // Walks c = 0 .. T+1 checking control timing; returns in the DONE cycle.
    task automatic check_run(input string nm, input bit edges);
        logic [DW-1:0] exp_a3;
        logic [DW-1:0] exp_b0;
        for (int c = 0; c <= T + 1; c++) begin
            check($sformatf("%s_busy_c%0d", nm, c), 128'(bus.busy), 128'(1));
            check($sformatf("%s_done_c%0d", nm, c), 128'(bus.done), 128'(c == T + 1));
            check($sformatf("%s_rden_c%0d", nm, c), 128'(bus.rd_en), 128'(c < K));
            check($sformatf("%s_addr_c%0d", nm, c), 128'(bus.rd_addr), (c < K) ? 128'(c) : 128'(0));
            check($sformatf("%s_en_c%0d", nm, c), 128'(bus.pe_enable), 128'(c >= 1 && c <= T));
            check($sformatf("%s_clr_c%0d", nm, c), 128'(bus.pe_clear), 128'(c == 1));
            if (edges) begin
                exp_a3 = (c >= 4 && c <= 7) ? DW'(10 + c - 4) : '0;
                exp_b0 = (c >= 1 && c <= 4) ? DW'(100 + 10 * (c - 1)) : '0;
                check($sformatf("%s_a3_c%0d", nm, c), 128'(bus.a_edge[3*DW +: DW]), 128'(exp_a3));
                check($sformatf("%s_b0_c%0d", nm, c), 128'(bus.b_edge[0 +: DW]), 128'(exp_b0));
            end
            if (c == T + 1) begin
                check($sformatf("%s_aedge_done", nm), 128'(bus.a_edge), 128'(0));
                check($sformatf("%s_bedge_done", nm), 128'(bus.b_edge), 128'(0));
            end else begin
                tick();
            end
        end
    endtask

    task automatic load_skew_data();
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
                a_mem[k][i] = DW'(70 - 20 * i + k);
                b_mem[k][i] = DW'(100 + 10 * k + i);
            end
    endtask

    task automatic load_int_data(input int scale);
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
                a_mem[k][i] = DW'(i + k);
                b_mem[k][i] = (k == i) ? DW'(scale) : '0;
            end
    endtask

    task automatic check_c(input string nm, input int scale);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s_c%0d%0d", nm, i, j), 128'(pc[i][j]), 128'(scale * (i + j)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b1;
        load_skew_data();

        // Reset dominates START.
        tick();
        tick();
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_done", 128'(bus.done), 128'(0));
        check("rst_rden", 128'(bus.rd_en), 128'(0));
        check("rst_addr", 128'(bus.rd_addr), 128'(0));
        check("rst_en", 128'(bus.pe_enable), 128'(0));
        check("rst_clr", 128'(bus.pe_clear), 128'(0));
        check("rst_aedge", 128'(bus.a_edge), 128'(0));
        check("rst_bedge", 128'(bus.b_edge), 128'(0));
        bus.start = 1'b0;
        reset     = 1'b0;
        tick();
        check("idle_busy", 128'(bus.busy), 128'(0));
        check("idle_done", 128'(bus.done), 128'(0));

        // Basic run with skew/zero-fill checks.
        start_run(1'b0);
        check_run("run", 1'b1);
        tick();
        check("post_busy", 128'(bus.busy), 128'(0));
        check("post_done", 128'(bus.done), 128'(0));

        // Integration: B = I, then B = 2I relying on pe_clear.
        load_int_data(1);
        start_run(1'b0);
        check_run("int1", 1'b0);
        check_c("int1", 1);
        tick();
        load_int_data(2);
        start_run(1'b0);
        check_run("int2", 1'b0);
        check_c("int2", 2);
        tick();

        // START held: ignored in RUN, accepted in DONE for a back-to-back run.
        load_skew_data();
        start_run(1'b1);
        check_run("hold1", 1'b1);
        tick();
        bus.start = 1'b0;
        check_run("hold2", 1'b1);
        tick();
        check("hold_idle", 128'(bus.busy), 128'(0));

        // Reset in the middle of a run.
        start_run(1'b0);
        for (int c = 0; c < 5; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", 128'(bus.busy), 128'(0));
        check("mrst_en", 128'(bus.pe_enable), 128'(0));
        check("mrst_done", 128'(bus.done), 128'(0));
        check("mrst_aedge", 128'(bus.a_edge), 128'(0));
        check("mrst_bedge", 128'(bus.b_edge), 128'(0));
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("mrst_nodone_%0d", c), 128'(bus.done), 128'(0));
        end
        start_run(1'b0);
        check_run("rerun", 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
